// File: rtl/fp_neuron_mac.sv
// fp_neuron_mac: sequential single-precision dot-product engine.
//   y = sum(x[k]*w[k]) + bias over N_TERMS streamed pairs.
//   One multiplier and one adder, both round-to-nearest-even. Subnormals are
//   treated as zero, overflow gives Inf, and an Inf/NaN operand is forced to +0.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start_i, bias_i            begin a dot product (IDLE only), bias captured with it
//   x_i, w_i, in_valid_i       operand pair, in_ready_o accepts it (ACC only)
//   y_o, out_valid_o           result handshake, out_ready_i consumes it
//   busy_o                     engine not idle
//   exc_o                      an exponent of 0xFF was seen in this dot product
// Optional feature: define FP_NEURON_RELU_EN to clamp negative results to +0.0.
module fp_neuron_mac #(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] bias_i,
  input  logic [31:0] x_i,
  input  logic [31:0] w_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [31:0] y_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        busy_o,
  output logic        exc_o
);

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

  state_t             state, state_nx;
  logic [31:0]        acc, prod_q, prod_nx, y_res;
  logic               prod_v, exc, beat, beat_exc;
  logic [CNT_W-1:0]   cnt;

  function automatic logic [31:0] sanitize(input logic [31:0] v);
    return (v[30:23] == 8'hFF) ? '0 : v;
  endfunction

  // Round-to-nearest-even on {exponent, mantissa}; a mantissa carry ripples into the exponent.
  function automatic logic [31:0] fp_pack(input logic s, input logic signed [10:0] e,
                                          input logic [22:0] m, input logic g, input logic st);
    logic [33:0]        ext;
    logic signed [10:0] e2;
    ext = {e, m} + 34'(g & (st | m[0]));
    e2  = $signed(ext[33:23]);
    if (e2 >= 11'sd255) return {s, 8'hFF, 23'b0};
    if (e2 <= 11'sd0)   return {s, 31'b0};
    return {s, ext[30:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a0, input logic [31:0] b0);
    logic [31:0]        a, b;
    logic               s;
    logic [47:0]        p;
    logic signed [10:0] e;
    a = sanitize(a0);
    b = sanitize(b0);
    s = a[31] ^ b[31];
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'b0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = $signed({3'b0, a[30:23]}) + $signed({3'b0, b[30:23]}) - 11'sd127;
    if (p[47]) return fp_pack(s, e + 11'sd1, p[46:24], p[23], |p[22:0]);
    return fp_pack(s, e, p[45:23], p[22], |p[21:0]);
  endfunction

  // Aligned mantissas carry guard, round and sticky bits (27 bits total).
  function automatic logic [31:0] fp_add(input logic [31:0] a0, input logic [31:0] b0);
    logic [31:0]        a, b, t;
    logic [7:0]         d;
    logic [49:0]        wide;
    logic [26:0]        big, sm, diff;
    logic [27:0]        sum;
    logic signed [10:0] e;
    logic [4:0]         lz;
    logic               found;
    a = sanitize(a0);
    b = sanitize(b0);
    if (a[30:23] == 8'h00 && b[30:23] == 8'h00) return {a[31] & b[31], 31'b0};
    if (a[30:23] == 8'h00) return b;
    if (b[30:23] == 8'h00) return a;
    if (a[30:0] < b[30:0]) begin
      t = a;
      a = b;
      b = t;
    end
    d    = a[30:23] - b[30:23];
    wide = {1'b1, b[22:0], 26'b0} >> ((d > 8'd49) ? 8'd49 : d);
    big  = {1'b1, a[22:0], 3'b000};
    sm   = {wide[49:24], |wide[23:0]};
    e    = $signed({3'b0, a[30:23]});
    if (a[31] == b[31]) begin
      sum = {1'b0, big} + {1'b0, sm};
      if (sum[27]) return fp_pack(a[31], e + 11'sd1, sum[26:4], sum[3], |sum[2:0]);
      return fp_pack(a[31], e, sum[25:3], sum[2], |sum[1:0]);
    end
    diff = big - sm;
    if (diff == '0) return '0;
    lz    = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 27; i++) begin
      if (!found) begin
        if (diff[26-i]) found = 1'b1;
        else            lz = lz + 5'd1;
      end
    end
    diff = diff << lz;
    return fp_pack(a[31], e - $signed({6'b0, lz}), diff[25:3], diff[2], |diff[1:0]);
  endfunction

  assign beat     = in_valid_i & in_ready_o;
  assign prod_nx  = fp_mul(x_i, w_i);
  assign beat_exc = (x_i[30:23] == 8'hFF) | (w_i[30:23] == 8'hFF) | (prod_nx[30:23] == 8'hFF);

`ifdef FP_NEURON_RELU_EN
  assign y_res = acc[31] ? '0 : acc;
`else
  assign y_res = acc;
`endif

  always_comb begin
    state_nx = state;
    busy_o   = (state != IDLE);
    case (state)
      IDLE:  if (start_i) state_nx = ACC;
      // Leaves one cycle after the last beat so its product is folded in on the way out.
      ACC:   if (cnt == CNT_W'(N_TERMS)) state_nx = DRAIN;
      DRAIN: state_nx = DONE;
      DONE:  if (out_valid_o && out_ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      prod_q      <= '0;
      prod_v      <= 1'b0;
      cnt         <= '0;
      exc         <= 1'b0;
      in_ready_o  <= 1'b0;
      out_valid_o <= 1'b0;
      y_o         <= '0;
      exc_o       <= 1'b0;
    end else begin
      state  <= state_nx;
      prod_v <= beat;
      if (state == IDLE && start_i) begin
        acc        <= bias_i;
        cnt        <= '0;
        exc        <= (bias_i[30:23] == 8'hFF);
        in_ready_o <= 1'b1;
      end else if (prod_v) begin
        acc <= fp_add(acc, prod_q);
      end
      if (beat) begin
        prod_q <= prod_nx;
        cnt    <= cnt + CNT_W'(1);
        if (beat_exc) exc <= 1'b1;
        if (cnt == CNT_W'(N_TERMS - 1)) in_ready_o <= 1'b0;
      end
      if (state == DONE && !out_valid_o) begin
        out_valid_o <= 1'b1;
        y_o         <= y_res;
        exc_o       <= exc;
      end else if (out_valid_o && out_ready_i) begin
        out_valid_o <= 1'b0;
        exc_o       <= 1'b0;
      end
    end
  end

endmodule
